// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller: state encodings,
// opcodes, ALU op codes, datapath mux selects and the instruction-class type.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic load;
    logic store;
    logic rtype;
    logic itype;
    logic branch;
    logic jal;
  } iclass_t;

endpackage

// File: rtl/mc_opcode_dec.sv
// Opcode decoder: classifies op into a one-hot instruction class, selects the
// immediate format and flags opcodes the controller does not support.
module mc_opcode_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output iclass_t    o_cls,
  output logic [1:0] o_imm_src,
  output logic       o_illegal
);

  always_comb begin
    o_cls     = '0;
    o_imm_src = IMM_I;
    o_illegal = 1'b0;
    case (i_op)
      OP_LOAD:   o_cls.load = 1'b1;
      OP_STORE: begin
        o_cls.store = 1'b1;
        o_imm_src   = IMM_S;
      end
      OP_RTYPE:  o_cls.rtype = 1'b1;
      OP_ITYPE:  o_cls.itype = 1'b1;
      OP_BRANCH: begin
        o_cls.branch = 1'b1;
        o_imm_src    = IMM_B;
      end
      OP_JAL: begin
        o_cls.jal = 1'b1;
        o_imm_src = IMM_J;
      end
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style sequencer for the shared multicycle RV32I datapath.
// Optional performance counters are enabled with `define MC_CTRL_PERF_CNT_EN.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [1:0]         imm_src,
  output logic [1:0]         alu_op,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_o
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
`endif
);

  state_t     r_state;
  state_t     w_next;
  iclass_t    w_cls;
  logic [1:0] w_imm_src;
  logic       w_dec_illegal;
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;

  mc_opcode_dec u_dec (
    .i_op      (op),
    .o_cls     (w_cls),
    .o_imm_src (w_imm_src),
    .o_illegal (w_dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = S_FETCH;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    result_src  = RES_ALUOUT;
    alu_op      = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        w_next     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        w_illegal = w_dec_illegal;
        if (w_cls.load || w_cls.store) w_next = S_MEMADR;
        else if (w_cls.rtype)          w_next = S_EXECR;
        else if (w_cls.itype)          w_next = S_EXECI;
        else if (w_cls.branch)         w_next = S_BRANCH;
        else if (w_cls.jal)            w_next = S_JAL;
        else                           w_next = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        w_next  = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        w_next      = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        // Only beq/bne are supported; other branch funct3 values fall through untaken.
        w_pc_write = (funct3[2:1] == 2'b00) ? (zero ^ funct3[0]) : 1'b0;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign imm_src       = w_imm_src;
  assign pc_write      = w_pc_write  & ~rst;
  assign ir_write      = w_ir_write  & ~rst;
  assign mem_write     = w_mem_write & ~rst;
  assign reg_write     = w_reg_write & ~rst;
  assign illegal_instr = w_illegal   & ~rst;
  assign state_o       = STATE_W'(r_state);

`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;
  logic        w_retire;

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BRANCH) ||
                    ((r_state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire) r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction-level phase sequences drive
// a reference table; a negedge monitor pops expected outputs and compares.
module tb_multicycle_ctrl;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                 P_MEMWB = 4, P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7,
                 P_ALUWB = 8, P_BRANCH = 9, P_JAL = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, alu_op;
  logic [3:0] state_o;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_op(alu_op), .illegal_instr(illegal_instr),
    .state_o(state_o)
`ifdef MC_CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] v;
    int unsigned cyc;
    int unsigned ret;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned m_cyc = 0;
  int unsigned m_ret = 0;
  bit          rnd_rst_en = 0;

  // 0 load, 1 store, 2 R, 3 I, 4 branch, 5 jal, 6 unsupported
  function automatic int cls_of(input logic [6:0] o);
    case (o)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      default:    return 6;
    endcase
  endfunction

  // Packed as {state, pc_write, ir_write, adr_src, mem_write, reg_write,
  // illegal, alu_src_a, alu_src_b, result_src, imm_src, alu_op}.
  function automatic logic [19:0] model(input int ph, input logic [6:0] o,
      input logic [2:0] f3, input logic z, input logic mr, input logic r);
    logic pcw, irw, adr, mw, rw, ill;
    logic [1:0] a, b, res, imm, aop;
    {pcw, irw, adr, mw, rw, ill} = '0;
    {a, b, res, aop} = '0;
    case (cls_of(o))
      1:       imm = 2'b01;
      4:       imm = 2'b10;
      5:       imm = 2'b11;
      default: imm = 2'b00;
    endcase
    case (ph)
      P_FETCH:    begin b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
      P_DECODE:   begin a = 2'b01; b = 2'b01; ill = (cls_of(o) == 6); end
      P_MEMADR:   begin a = 2'b10; b = 2'b01; end
      P_MEMREAD:  adr = 1'b1;
      P_MEMWB:    begin res = 2'b01; rw = 1'b1; end
      P_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      P_EXECR:    begin a = 2'b10; aop = 2'b10; end
      P_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      P_ALUWB:    rw = 1'b1;
      P_BRANCH: begin
        a = 2'b10; aop = 2'b01;
        if (f3 == 3'b000)      pcw = z;
        else if (f3 == 3'b001) pcw = !z;
      end
      P_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    if (r) {pcw, irw, mw, rw, ill} = '0;
    return {4'(ph), pcw, irw, adr, mw, rw, ill, a, b, res, imm, aop};
  endfunction

  // One controller cycle in phase ph; ab reports that reset was applied.
  task automatic step(input int ph, input bit mr, input int zf, input bit frst,
                      output bit ab);
    exp_t e;
    rst       = frst || (rnd_rst_en && ($urandom_range(0, 99) < 2));
    mem_ready = mr;
    zero      = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
    e.v   = model(ph, op, funct3, zero, mem_ready, rst);
    e.cyc = m_cyc;
    e.ret = m_ret;
    exp_q.push_back(e);
    if (rst) begin
      m_cyc = 0;
      m_ret = 0;
    end else begin
      m_cyc++;
      if (ph == P_MEMWB || ph == P_ALUWB || ph == P_BRANCH ||
          (ph == P_MEMWRITE && mr))
        m_ret++;
    end
    ab = rst;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic bit pick_ready(input int stalls, input int done);
    if (stalls >= 0) return (done >= stalls);
    return ($urandom_range(0, 3) != 0);
  endfunction

  // stalls<0 randomises memory waits; rst_stall resets on the first MEMREAD stall.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input int stalls, input int zf, input bit rst_stall);
    bit ab, mr;
    int n;
    op = o;
    funct3 = f3;
    n = 0;
    do begin
      mr = (stalls >= 0) ? 1'b1 : pick_ready(-1, 0);
      step(P_FETCH, mr, zf, 0, ab);
      if (ab) return;
    end while (!mr);
    step(P_DECODE, 1'($urandom_range(0, 1)), zf, 0, ab);
    if (ab) return;
    case (cls_of(o))
      0, 1: begin
        step(P_MEMADR, 1'($urandom_range(0, 1)), zf, 0, ab);
        if (ab) return;
        do begin
          mr = pick_ready(stalls, n);
          step((cls_of(o) == 0) ? P_MEMREAD : P_MEMWRITE, mr, zf,
               rst_stall && !mr, ab);
          n++;
          if (ab) return;
        end while (!mr);
        if (cls_of(o) == 0) step(P_MEMWB, 1'($urandom_range(0, 1)), zf, 0, ab);
      end
      2: begin
        step(P_EXECR, 1'($urandom_range(0, 1)), zf, 0, ab);
        if (!ab) step(P_ALUWB, 1'($urandom_range(0, 1)), zf, 0, ab);
      end
      3: begin
        step(P_EXECI, 1'($urandom_range(0, 1)), zf, 0, ab);
        if (!ab) step(P_ALUWB, 1'($urandom_range(0, 1)), zf, 0, ab);
      end
      4: step(P_BRANCH, 1'($urandom_range(0, 1)), zf, 0, ab);
      5: begin
        step(P_JAL, 1'($urandom_range(0, 1)), zf, 0, ab);
        if (!ab) step(P_ALUWB, 1'($urandom_range(0, 1)), zf, 0, ab);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [19:0] got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {state_o, pc_write, ir_write, adr_src, mem_write, reg_write,
             illegal_instr, alu_src_a, alu_src_b, result_src, imm_src, alu_op};
      vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL outputs t=%0t op=%b f3=%b zero=%b mr=%b rst=%b got=%h exp=%h",
                 $time, op, funct3, zero, mem_ready, rst, got, e.v);
      end
`ifdef MC_CTRL_PERF_CNT_EN
      vectors++;
      if (cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
        miscompares++;
        $display("FAIL counters t=%0t got cyc=%0d ret=%0d exp cyc=%0d ret=%0d",
                 $time, cycle_cnt, instret_cnt, e.cyc, e.ret);
      end
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] ILLEGALS [5] = '{7'b0110111, 7'b0000000, 7'b1111111,
                                         7'b0010111, 7'b1100111};

  initial begin
    bit ab;
    logic [6:0] o;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(P_FETCH, 1'b1, 0, 1, ab);            // reset holds strobes low in FETCH
    // directed cases
    run_instr(7'b0000011, 3'b010, 0, 0, 0);   // lw, no stall
    run_instr(7'b0100011, 3'b010, 3, 0, 0);   // sw, 3 stall cycles in MEMWRITE
    run_instr(7'b0110011, 3'b000, 0, 0, 0);   // R-type
    run_instr(7'b0010011, 3'b000, 0, 0, 0);   // addi
    run_instr(7'b1100011, 3'b000, 0, 1, 0);   // beq taken
    run_instr(7'b1100011, 3'b001, 0, 1, 0);   // bne not taken
    run_instr(7'b1100011, 3'b000, 0, 0, 0);   // beq not taken
    run_instr(7'b1100011, 3'b100, 0, 1, 0);   // unsupported branch funct3
    run_instr(7'b1101111, 3'b000, 0, 0, 0);   // jal
    run_instr(7'b0110111, 3'b000, 0, 0, 0);   // lui: unsupported
    run_instr(7'b0000011, 3'b010, 2, 0, 1);   // reset during MEMREAD stall
    run_instr(7'b0000011, 3'b010, 0, 0, 0);   // clean lw after reset
    // random traffic with occasional resets
    rnd_rst_en = 1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0: o = 7'b0000011;
        1: o = 7'b0100011;
        2: o = 7'b0110011;
        3: o = 7'b0010011;
        4: o = 7'b1100011;
        5: o = 7'b1101111;
        6: o = ILLEGALS[$urandom_range(0, 4)];
        default: o = 7'($urandom);
      endcase
      run_instr(o, 3'($urandom_range(0, 7)), -1, -1, 0);
    end
    rnd_rst_en = 0;
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences the shared multicycle RV32I datapath: one ALU, one unified memory port, and PC/IR/ALUOut/Data registers.
- Per cycle it drives mux selects, write strobes and the 2-bit alu_op consumed by the ALU control decoder.
- Supports lw, sw, R-type, I-type ALU, beq/bne and jal.
- Stalls on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of state register and debug state output.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instr[6:0] from IR.
- funct3  in  3  instr[14:12] from IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC register enable.
- ir_write  out  1  IR/OldPC register enable.
- adr_src  out  1  memory address: 0=PC, 1=Result.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 reg.
- alu_src_b  out  2  00=rs2 reg, 01=ImmExt, 10=const 4.
- result_src  out  2  00=ALUOut, 01=Data, 10=ALU result.
- imm_src  out  2  00=I, 01=S, 10=B, 11=J.
- alu_op  out  2  00=add, 01=sub, 10=decode funct3/funct7.
- illegal_instr  out  1  one-cycle pulse in DECODE for unsupported opcode.
- state_o  out  STATE_W  current state, debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10. Encodings 11-15 are illegal and go to FETCH next cycle.
- Outputs are combinational from state and inputs. Every output not listed for a state is 0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while !mem_ready; otherwise goes to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECR.
    - 0010011 -> EXECI.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - Anything else -> FETCH with illegal_instr=1.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. mem_write stays asserted until mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero XOR funct3[0] (beq/bne).
  - Other funct3 values: pc_write=0 (not taken). -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB (writes PC+4 to rd).
- imm_src decoded from op in every state: S for 0100011, B for 1100011, J for 1101111, otherwise I.
- Reset:
  - While rst=1, all strobes (pc_write, ir_write, mem_write, reg_write, illegal_instr) are forced to 0.
  - The state register loads FETCH on the rising edge with rst=1, including mid-instruction or mid-stall.
  - state_o=0 after reset.
- Latency in cycles with mem_ready=1: lw 5; sw 4; R/I 4; branch 3; jal 4.
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE and ignored elsewhere.

Optional Feature:
- Macro MC_CTRL_PERF_CNT_EN.
- When defined, adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - cycle_cnt increments every cycle rst=0.
  - instret_cnt increments on the last cycle of each instruction: MEMWB, MEMWRITE with mem_ready, ALUWB, BRANCH.
  - Both wrap 0xFFFFFFFF->0 and reset to 0.
- When undefined, the ports and counters do not exist and the base behaviour is unchanged.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings;
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL);
  - alu_op codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - mux select constants for src A/B, result and imm.
- One combinational sub-module, mc_opcode_dec: op -> instruction class (one-hot), imm_src, illegal flag. The FSM uses it for DECODE transitions.

Test Plan:
- Reset, then lw (op=0000011), mem_ready=1 -> states 0,1,2,3,4,0. reg_write=1 only in MEMWB; result_src=01 there.
- sw (op=0100011), mem_ready low 3 cycles in MEMWRITE -> mem_write high 4 cycles, imm_src=01, then FETCH.
- add/sub R-type (op=0110011) -> EXECR alu_op=10, alu_src_b=00, then ALUWB reg_write=1. addi -> EXECI alu_src_b=01.
- beq with zero=1 -> pc_write=1 in BRANCH, alu_op=01. bne with zero=1 -> pc_write=0. beq with zero=0 -> pc_write=0.
- jal -> JAL pc_write=1, imm_src=11, then ALUWB reg_write=1. op=0110111 -> illegal_instr pulse in DECODE, next state FETCH.
- rst asserted during MEMREAD stall -> next edge state_o=0, no strobes while rst=1. With MC_CTRL_PERF_CNT_EN, counters read 0.
